// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle for the pipelined MIPS control path.
// Opcodes, funct codes, ALU operation codes and the per-instruction control record.
package ctrl_pkg;

    localparam int ALUC_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_NOR = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b1000;
    localparam logic [ALUC_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALUC_W-1:0] ALU_SRL = 4'b1010;
    localparam logic [ALUC_W-1:0] ALU_LUI = 4'b1011;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10
    } branch_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC4 = 2'b10
    } memtoreg_e;

    typedef struct packed {
        logic [ALUC_W-1:0] alucode;
        logic              alusrc_b;
        logic              regdst;
        branch_e           branch;
        logic              jump;
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        memtoreg_e         memtoreg;
        logic              illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to control bundle plus
// register-source usage flags for the load-use detector.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EXT_EN = 1'b1
) (
    input  logic [31:0]  i_inst,
    output ctrl_bundle_t o_ctrl,
    output logic         o_uses_rs,
    output logic         o_uses_rt
);

    logic [5:0]   w_op;
    logic [5:0]   w_fn;
    logic         w_ill;
    logic         w_rs;
    logic         w_rt;
    ctrl_bundle_t w_b;
    logic         w_unused_fields;

    assign w_op = i_inst[31:26];
    assign w_fn = i_inst[5:0];
    assign w_unused_fields = ^i_inst[25:6];

    always_comb begin
        w_b   = '0;
        w_ill = 1'b0;
        w_rs  = 1'b1;
        w_rt  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_b.regdst   = 1'b1;
                w_b.regwrite = 1'b1;
                w_rt         = 1'b1;
                case (w_fn)
                    FN_ADD: w_b.alucode = ALU_ADD;
                    FN_SUB: w_b.alucode = ALU_SUB;
                    FN_AND: w_b.alucode = ALU_AND;
                    FN_OR:  w_b.alucode = ALU_OR;
                    FN_XOR: w_b.alucode = ALU_XOR;
                    FN_NOR: w_b.alucode = ALU_NOR;
                    FN_SLT: begin
                        w_b.alucode = ALU_SLT;
                        w_ill       = !EXT_EN;
                    end
                    FN_SLL: begin
                        w_b.alucode = ALU_SLL;
                        w_rs        = 1'b0;
                        w_ill       = !EXT_EN;
                    end
                    FN_SRL: begin
                        w_b.alucode = ALU_SRL;
                        w_rs        = 1'b0;
                        w_ill       = !EXT_EN;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                w_b.alusrc_b = 1'b1;
                w_b.regwrite = 1'b1;
                case (w_op)
                    OP_ANDI: w_b.alucode = ALU_AND;
                    OP_ORI:  w_b.alucode = ALU_OR;
                    OP_XORI: w_b.alucode = ALU_XOR;
                    default: w_b.alucode = ALU_ADD;
                endcase
            end
            OP_LUI: begin
                w_b.alucode  = ALU_LUI;
                w_b.alusrc_b = 1'b1;
                w_b.regwrite = 1'b1;
                w_rs         = 1'b0;
                w_ill        = !EXT_EN;
            end
            OP_LW: begin
                w_b.alucode  = ALU_ADD;
                w_b.alusrc_b = 1'b1;
                w_b.memread  = 1'b1;
                w_b.regwrite = 1'b1;
                w_b.memtoreg = M2R_MEM;
            end
            OP_SW: begin
                w_b.alucode  = ALU_ADD;
                w_b.alusrc_b = 1'b1;
                w_b.memwrite = 1'b1;
                w_rt         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_b.alucode = ALU_SUB;
                w_b.branch  = (w_op == OP_BEQ) ? BR_BEQ : BR_BNE;
                w_rt        = 1'b1;
            end
            OP_J, OP_JAL: begin
                w_b.jump = 1'b1;
                w_rs     = 1'b0;
                w_ill    = !EXT_EN;
                if (w_op == OP_JAL) begin
                    w_b.regwrite = 1'b1;
                    w_b.memtoreg = M2R_PC4;
                end
            end
            default: w_ill = 1'b1;
        endcase
        // An undecodable instruction has no side effects and reads no registers,
        // so it can never trigger a load-use stall.
        if (w_ill) begin
            w_b         = '0;
            w_b.illegal = 1'b1;
            w_rs        = 1'b0;
            w_rt        = 1'b0;
        end
    end

    assign o_ctrl    = w_b;
    assign o_uses_rs = w_rs;
    assign o_uses_rt = w_rt;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: decodes ID, carries controls through ID/EX, EX/MEM,
// MEM/WB, and generates load-use stall and branch/jump flush.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALU_W  = 4,
    parameter int REG_AW = 5,
    parameter bit EXT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_inst,
    input  logic              id_valid,
    input  logic              ex_take,
    output logic              stall,
    output logic              flush,
    output logic [ALU_W-1:0]  ex_alucode,
    output logic              ex_alusrc_b,
    output logic              ex_regdst,
    output logic [1:0]        ex_branch,
    output logic              ex_jump,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_regwrite,
    output logic [1:0]        wb_memtoreg,
    output logic              ex_illegal
);

    ctrl_bundle_t      w_dec;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic [REG_AW-1:0] w_id_rs;
    logic [REG_AW-1:0] w_id_rt;
    logic              w_load_use;

    ctrl_bundle_t      r_idex;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_regwrite;
    memtoreg_e         r_mem_memtoreg;
    logic              r_wb_regwrite;
    memtoreg_e         r_wb_memtoreg;

    ctrl_decode #(
        .EXT_EN(EXT_EN)
    ) u_decode (
        .i_inst   (id_inst),
        .o_ctrl   (w_dec),
        .o_uses_rs(w_uses_rs),
        .o_uses_rt(w_uses_rt)
    );

    assign w_id_rs = id_inst[25 -: REG_AW];
    assign w_id_rt = id_inst[20 -: REG_AW];

    assign w_load_use = r_idex.memread & id_valid & (r_ex_rt != '0) &
                        ((w_uses_rs & (w_id_rs == r_ex_rt)) |
                         (w_uses_rt & (w_id_rt == r_ex_rt)));

    // A taken branch discards the instruction in ID, so there is nothing to stall for.
    assign flush = ex_take;
    assign stall = w_load_use & ~ex_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex         <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= M2R_ALU;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= M2R_ALU;
        end else begin
            if (ex_take || w_load_use || !id_valid) begin
                r_idex  <= '0;
                r_ex_rs <= '0;
                r_ex_rt <= '0;
            end else begin
                r_idex  <= w_dec;
                r_ex_rs <= w_id_rs;
                r_ex_rt <= w_id_rt;
            end
            r_mem_read     <= r_idex.memread;
            r_mem_write    <= r_idex.memwrite;
            r_mem_regwrite <= r_idex.regwrite;
            r_mem_memtoreg <= r_idex.memtoreg;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
        end
    end

    assign ex_alucode  = ALU_W'(r_idex.alucode);
    assign ex_alusrc_b = r_idex.alusrc_b;
    assign ex_regdst   = r_idex.regdst;
    assign ex_branch   = r_idex.branch;
    assign ex_jump     = r_idex.jump;
    assign ex_rs       = r_ex_rs;
    assign ex_rt       = r_ex_rt;
    assign ex_illegal  = r_idex.illegal;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_memtoreg = r_wb_memtoreg;

endmodule
